axi_sel_arbiter: RTL and testbench

AXI_SEL_ARBITER -- requirements
Module: axi_sel_arbiter

---
 rtl/axi_sel_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_sel_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sel_arbiter.sv
// -----------------------------------------------------------------------------
// axi_sel_arbiter
//
// Round-robin arbiter that hands a single shared AXI port to one of NUM_REQ
// requesters. An owner keeps the port while it holds its request. When it
// releases the port, the arbiter drains every outstanding write/read burst
// before a new owner is selected, so responses are never steered to the wrong
// requester.
//
// Parameters
//   NUM_REQ     number of requesters (>= 2)
//   MAX_OUTSTD  outstanding AW / AR limit per direction (>= 1)
//   QUANTUM     time slice in cycles (only with AXI_SEL_QUANTUM_EN)
//
// Ports
//   clk_axi       clock, rising edge
//   arst_axi      synchronous active-high reset
//   req_i         per-requester level request
//   grant_o       one-hot grant or all-zero
//   axi_sel_o     index of the current/last owner (AXI mux select)
//   aw_hs_i       AW handshake on the shared port
//   ar_hs_i       AR handshake on the shared port
//   w_last_hs_i   W handshake with WLAST
//   b_hs_i        B handshake
//   r_last_hs_i   R handshake with RLAST
//   aw_block_o    mask AWVALID at the mux
//   ar_block_o    mask ARVALID at the mux
//   busy_o        FSM is not IDLE
//
// Build option
//   AXI_SEL_QUANTUM_EN  when defined, an owner is preempted after QUANTUM
//                       ACTIVE cycles if another requester is waiting.
// -----------------------------------------------------------------------------
module axi_sel_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_OUTSTD = 4,
    parameter int QUANTUM    = 64
) (
    input  logic                       clk_axi,
    input  logic                       arst_axi,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] axi_sel_o,
    input  logic                       aw_hs_i,
    input  logic                       ar_hs_i,
    input  logic                       w_last_hs_i,
    input  logic                       b_hs_i,
    input  logic                       r_last_hs_i,
    output logic                       aw_block_o,
    output logic                       ar_block_o,
    output logic                       busy_o
);

    localparam int SW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_OUTSTD + 1);
    localparam logic [CW-1:0]      CNT_MAX  = CW'(MAX_OUTSTD);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [SW-1:0]      SEL_LAST = SW'(NUM_REQ - 1);
    localparam logic [SW-1:0]      SEL_ONE  = SW'(1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [SW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]      wd_cnt_q, wd_cnt_d;
    logic               aw_block_q, aw_block_d;
    logic               ar_block_q, ar_block_d;
    logic               busy_q, busy_d;

    logic               pick_found_s;
    logic [SW-1:0]      pick_idx_s;
    logic               q_expire_s;

    // Saturating up/down step; a simultaneous inc and dec cancel out.
    function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                               input logic          inc,
                                               input logic          dec);
        logic [CW-1:0] res;
        if (inc && !dec) begin
            res = (cnt != CNT_MAX) ? (cnt + CNT_ONE) : cnt;
        end else if (dec && !inc) begin
            res = (cnt != '0) ? (cnt - CNT_ONE) : cnt;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            int  idx;
            logic hit;
            idx          = (int'(rr_ptr_q) + i) % NUM_REQ;
            hit          = !pick_found_s && req_i[idx];
            pick_idx_s   = hit ? SW'(idx) : pick_idx_s;
            pick_found_s = pick_found_s | hit;
        end
    end

`ifdef AXI_SEL_QUANTUM_EN
    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(QUANTUM - 1);
    localparam logic [QW-1:0] Q_ONE  = QW'(1);

    logic [QW-1:0] q_cnt_q, q_cnt_d;

    // Slice counter: zero outside ACTIVE, counts up and parks at the last value.
    always_comb begin
        if (state_q != ST_ACTIVE) begin
            q_cnt_d = '0;
        end else if (q_cnt_q != Q_LAST) begin
            q_cnt_d = q_cnt_q + Q_ONE;
        end else begin
            q_cnt_d = q_cnt_q;
        end
    end

    // Preempt only when the slice is used up and someone else is waiting.
    assign q_expire_s = (q_cnt_q == Q_LAST) && (|(req_i & ~grant_q));

    // Slice counter register.
    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            q_cnt_q <= '0;
        end else begin
            q_cnt_q <= q_cnt_d;
        end
    end
`else
    assign q_expire_s = 1'b0;
`endif

    // Next-state, grant and counter logic; outputs are derived from next state.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        wr_cnt_d = cnt_step(wr_cnt_q, aw_hs_i, b_hs_i);
        rd_cnt_d = cnt_step(rd_cnt_q, ar_hs_i, r_last_hs_i);
        wd_cnt_d = cnt_step(wd_cnt_q, aw_hs_i, w_last_hs_i);
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_ACTIVE;
                    grant_d = ONE_HOT0 << pick_idx_s;
                    sel_d   = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!req_i[sel_q] || q_expire_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                // Requests are ignored here, so a re-raised req_i must re-arbitrate.
                if ((wr_cnt_q == '0) && (rd_cnt_q == '0) && (wd_cnt_q == '0)) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (sel_q == SEL_LAST) ? '0 : (sel_q + SEL_ONE);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        aw_block_d = (state_d != ST_ACTIVE) || (wr_cnt_d == CNT_MAX);
        ar_block_d = (state_d != ST_ACTIVE) || (rd_cnt_d == CNT_MAX);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, grant, counters and registered outputs.
    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wd_cnt_q   <= '0;
            aw_block_q <= 1'b1;
            ar_block_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            aw_block_q <= aw_block_d;
            ar_block_q <= ar_block_d;
            busy_q     <= busy_d;
        end
    end

`ifndef SYNTHESIS
    // Report counter overflow/underflow caused by the AXI side breaking protocol.
    always_ff @(posedge clk_axi) begin
        if (!arst_axi) begin
            if (aw_hs_i && !b_hs_i && (wr_cnt_q == CNT_MAX)) $error("axi_sel_arbiter: wr_cnt overflow");
            if (b_hs_i && !aw_hs_i && (wr_cnt_q == '0)) $error("axi_sel_arbiter: wr_cnt underflow");
            if (ar_hs_i && !r_last_hs_i && (rd_cnt_q == CNT_MAX)) $error("axi_sel_arbiter: rd_cnt overflow");
            if (r_last_hs_i && !ar_hs_i && (rd_cnt_q == '0)) $error("axi_sel_arbiter: rd_cnt underflow");
            if (aw_hs_i && !w_last_hs_i && (wd_cnt_q == CNT_MAX)) $error("axi_sel_arbiter: wd_cnt overflow");
            if (w_last_hs_i && !aw_hs_i && (wd_cnt_q == '0)) $error("axi_sel_arbiter: wd_cnt underflow");
        end
    end
`endif

    assign grant_o    = grant_q;
    assign axi_sel_o  = sel_q;
    assign aw_block_o = aw_block_q;
    assign ar_block_o = ar_block_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_axi_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_sel_arbiter
//
// Directed bench for axi_sel_arbiter (NUM_REQ=4, MAX_OUTSTD=4, QUANTUM=8).
// Inputs change 1 time unit after the rising edge; outputs are checked at the
// same point, i.e. they reflect the edge that was just taken.
// -----------------------------------------------------------------------------
module tb_axi_sel_arbiter;

    logic       clk_axi;
    logic       arst_axi;
    logic [3:0] req_i;
    logic [3:0] grant_o;
    logic [1:0] axi_sel_o;
    logic       aw_hs_i, ar_hs_i, w_last_hs_i, b_hs_i, r_last_hs_i;
    logic       aw_block_o, ar_block_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    axi_sel_arbiter #(
        .NUM_REQ    (4),
        .MAX_OUTSTD (4),
        .QUANTUM    (8)
    ) dut (
        .clk_axi     (clk_axi),
        .arst_axi    (arst_axi),
        .req_i       (req_i),
        .grant_o     (grant_o),
        .axi_sel_o   (axi_sel_o),
        .aw_hs_i     (aw_hs_i),
        .ar_hs_i     (ar_hs_i),
        .w_last_hs_i (w_last_hs_i),
        .b_hs_i      (b_hs_i),
        .r_last_hs_i (r_last_hs_i),
        .aw_block_o  (aw_block_o),
        .ar_block_o  (ar_block_o),
        .busy_o      (busy_o)
    );

    initial clk_axi = 1'b0;
    always #5 clk_axi = ~clk_axi;

    // Advance one edge and settle.
    task automatic tick();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        req_i = 4'b0000;
        aw_hs_i = 1'b0; ar_hs_i = 1'b0; w_last_hs_i = 1'b0;
        b_hs_i = 1'b0; r_last_hs_i = 1'b0;
        arst_axi = 1'b1;
        #1;
        tick();
        tick();
        // ---------------- reset state
        check_eq("rst_grant", 32'(grant_o), 32'h0);
        check_eq("rst_sel", 32'(axi_sel_o), 32'h0);
        check_eq("rst_awblk", 32'(aw_block_o), 32'h1);
        check_eq("rst_arblk", 32'(ar_block_o), 32'h1);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        arst_axi = 1'b0;
        tick();

        // ---------------- basic grant / drain / idle gap
        req_i = 4'b0101;
        tick();
        check_eq("b_grant0", 32'(grant_o), 32'h1);
        check_eq("b_sel0", 32'(axi_sel_o), 32'h0);
        check_eq("b_busy", 32'(busy_o), 32'h1);
        check_eq("b_awblk", 32'(aw_block_o), 32'h0);
        check_eq("b_arblk", 32'(ar_block_o), 32'h0);
        req_i = 4'b0100;
        tick();
        check_eq("b_drain_grant", 32'(grant_o), 32'h1);
        check_eq("b_drain_awblk", 32'(aw_block_o), 32'h1);
        check_eq("b_drain_busy", 32'(busy_o), 32'h1);
        tick();
        check_eq("b_idle_grant", 32'(grant_o), 32'h0);
        check_eq("b_idle_busy", 32'(busy_o), 32'h0);
        check_eq("b_idle_sel", 32'(axi_sel_o), 32'h0);
        tick();
        check_eq("b_grant2", 32'(grant_o), 32'h4);
        check_eq("b_sel2", 32'(axi_sel_o), 32'h2);

        // ---------------- round robin from a fresh reset
        req_i = 4'b0000;
        arst_axi = 1'b1;
        tick();
        arst_axi = 1'b0;
        tick();
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("rr_grant%0d", i), 32'(grant_o), 32'(4'b0001 << order[i]));
            check_eq($sformatf("rr_sel%0d", i), 32'(axi_sel_o), 32'(order[i]));
            if (i < 4) begin
                req_i[order[i]] = 1'b0;
                tick();
                // re-raise during DRAIN: must not keep the grant
                req_i = 4'b1111;
                tick();
                check_eq($sformatf("rr_gap%0d", i), 32'(grant_o), 32'h0);
            end
        end

        // ---------------- drain with outstanding traffic (owner 0)
        aw_hs_i = 1'b1; ar_hs_i = 1'b1;
        tick();
        ar_hs_i = 1'b0;
        tick();
        aw_hs_i = 1'b0;
        check_eq("d_awblk_act", 32'(aw_block_o), 32'h0);
        req_i = 4'b1110;
        tick();
        check_eq("d_awblk", 32'(aw_block_o), 32'h1);
        check_eq("d_arblk", 32'(ar_block_o), 32'h1);
        check_eq("d_sel", 32'(axi_sel_o), 32'h0);
        b_hs_i = 1'b1;
        tick();
        b_hs_i = 1'b0; w_last_hs_i = 1'b1; r_last_hs_i = 1'b1;
        tick();
        r_last_hs_i = 1'b0;
        tick();
        w_last_hs_i = 1'b0;
        tick();
        check_eq("d_hold_grant", 32'(grant_o), 32'h1);
        check_eq("d_hold_busy", 32'(busy_o), 32'h1);
        b_hs_i = 1'b1;
        tick();
        b_hs_i = 1'b0;
        check_eq("d_last_grant", 32'(grant_o), 32'h1);
        check_eq("d_last_arblk", 32'(ar_block_o), 32'h1);
        tick();
        check_eq("d_idle_grant", 32'(grant_o), 32'h0);
        check_eq("d_idle_busy", 32'(busy_o), 32'h0);
        check_eq("d_idle_sel", 32'(axi_sel_o), 32'h0);
        tick();
        check_eq("d_next_grant", 32'(grant_o), 32'h2);

        // ---------------- outstanding limit (owner 1)
        aw_hs_i = 1'b1;
        tick(); tick(); tick();
        check_eq("o_awblk3", 32'(aw_block_o), 32'h0);
        tick();
        aw_hs_i = 1'b0;
        check_eq("o_awblk4", 32'(aw_block_o), 32'h1);
        check_eq("o_arblk4", 32'(ar_block_o), 32'h0);
        b_hs_i = 1'b1; w_last_hs_i = 1'b1;
        tick();
        check_eq("o_awblk_b", 32'(aw_block_o), 32'h0);
        aw_hs_i = 1'b1;
        tick();
        check_eq("o_awblk_same", 32'(aw_block_o), 32'h0);
        b_hs_i = 1'b0; w_last_hs_i = 1'b0;
        tick();
        aw_hs_i = 1'b0;
        check_eq("o_awblk_full", 32'(aw_block_o), 32'h1);

        // ---------------- reset in DRAIN with wr_cnt = 3
        b_hs_i = 1'b1; w_last_hs_i = 1'b1;
        tick();
        b_hs_i = 1'b0; w_last_hs_i = 1'b0;
        req_i = 4'b0000;
        tick();
        check_eq("r_drain_busy", 32'(busy_o), 32'h1);
        arst_axi = 1'b1;
        tick();
        arst_axi = 1'b0;
        check_eq("r_busy", 32'(busy_o), 32'h0);
        check_eq("r_grant", 32'(grant_o), 32'h0);
        check_eq("r_sel", 32'(axi_sel_o), 32'h0);
        check_eq("r_awblk", 32'(aw_block_o), 32'h1);
        tick();
        req_i = 4'b0100;
        tick();
        check_eq("r_regrant", 32'(grant_o), 32'h4);
        req_i = 4'b0000;
        tick();
        tick();
        // a clean drain proves the counters were cleared
        check_eq("r_cnt_clear", 32'(busy_o), 32'h0);

        // ---------------- time slice
        req_i = 4'b0011;
        tick();
        check_eq("q_grant0", 32'(grant_o), 32'h1);
`ifdef AXI_SEL_QUANTUM_EN
        repeat (7) tick();
        check_eq("q_active7", 32'(aw_block_o), 32'h0);
        tick();
        check_eq("q_preempt_blk", 32'(aw_block_o), 32'h1);
        check_eq("q_preempt_grant", 32'(grant_o), 32'h1);
        tick();
        check_eq("q_gap", 32'(grant_o), 32'h0);
        tick();
        check_eq("q_grant1", 32'(grant_o), 32'h2);
        req_i = 4'b0001;
        tick(); tick(); tick();
        check_eq("q_back0", 32'(grant_o), 32'h1);
`else
        repeat (20) tick();
        check_eq("nq_grant", 32'(grant_o), 32'h1);
        check_eq("nq_awblk", 32'(aw_block_o), 32'h0);
        req_i = 4'b0001;
`endif
        repeat (20) tick();
        check_eq("solo_grant", 32'(grant_o), 32'h1);
        check_eq("solo_awblk", 32'(aw_block_o), 32'h0);
        check_eq("solo_busy", 32'(busy_o), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
